// File: rtl/edge_detector.sv
// Sampled single-bit edge detector with registered one-clock rise/fall pulses.
// Define EDGE_DET_SYNC_EN to insert a 2-flop synchronizer so a_i may be asynchronous to clk.
module edge_detector #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a_i,
  output logic rising_edge,
  output logic falling_edge
);

  logic w_sample;
  logic r_prev;
  logic r_rise;
  logic r_fall;

`ifdef EDGE_DET_SYNC_EN
  // Synchronizer resets to INIT_LEVEL so no spurious edge is seen right after reset.
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {2{INIT_LEVEL}};
    end else begin
      r_sync <= {r_sync[0], a_i};
    end
  end

  assign w_sample = r_sync[1];
`else
  assign w_sample = a_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= INIT_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_sample;
      r_rise <= w_sample & ~r_prev;
      r_fall <= ~w_sample & r_prev;
    end
  end

  assign rising_edge  = r_rise;
  assign falling_edge = r_fall;

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: two instances (INIT_LEVEL 0 and 1) on shared stimulus.
module tb_edge_detector;

`ifdef EDGE_DET_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic a_i   = 1'b1;
  logic r0, f0, r1, f1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit count_en = 1'b0;

  edge_detector #(.INIT_LEVEL(1'b0)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .rising_edge (r0),
    .falling_edge(f0)
  );

  edge_detector #(.INIT_LEVEL(1'b1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .rising_edge (r1),
    .falling_edge(f1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a_i as seen at each posedge since the last reset release.
  bit samples[$];
  always @(posedge clk or posedge reset) begin
    if (reset) samples.delete();
    else samples.push_back(a_i);
  end

  // Value of s at posedge k (k=0 means the reset history).
  function automatic bit s_at(input int k, input bit init);
    int idx = k - D;
    if (k < 1 || idx < 1) return init;
    return samples[idx-1];
  endfunction

  function automatic bit exp_rise(input bit init);
    int n = samples.size();
    if (n == 0) return 1'b0;
    return s_at(n, init) & ~s_at(n - 1, init);
  endfunction

  function automatic bit exp_fall(input bit init);
    int n = samples.size();
    if (n == 0) return 1'b0;
    return ~s_at(n, init) & s_at(n - 1, init);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rise0", r0, 1'b0);
      check("rst_fall0", f0, 1'b0);
      check("rst_rise1", r1, 1'b0);
      check("rst_fall1", f1, 1'b0);
    end else begin
      check("model_rise0", r0, exp_rise(1'b0));
      check("model_fall0", f0, exp_fall(1'b0));
      check("model_rise1", r1, exp_rise(1'b1));
      check("model_fall1", f1, exp_fall(1'b1));
    end
    check("mutex0", r0 & f0, 1'b0);
    check("mutex1", r1 & f1, 1'b0);
    if (count_en) pulses += int'(r0) + int'(f0);
  end

  task automatic cycle(input logic v);
    a_i = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic seq_single [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic seq_toggle [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int trans;
    logic prev_v;
    logic v;

    // Reset held with a_i high: no pulses.
    reset = 1'b1;
    a_i   = 1'b1;
    repeat (2) @(negedge clk);
    check("lit_reset_rise0", r0, 1'b0);

    // Post-reset edge, then async reset in the middle of the pulse.
    reset = 1'b0;
    for (int k = 1; k <= 1 + D; k++) begin
      cycle(1'b1);
      check("lit_post_rise0", r0, (k == 1 + D));
      check("lit_post_fall0", f0, 1'b0);
      check("lit_post_rise1", r1, 1'b0);
      check("lit_post_fall1", f1, 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    check("lit_async_rise0", r0, 1'b0);
    check("lit_async_fall0", f0, 1'b0);
    a_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Single pulse; INIT_LEVEL=1 instance also reports the initial falling edge.
    for (int k = 1; k <= 7 + D; k++) begin
      cycle((k <= 7) ? seq_single[k-1] : 1'b0);
      check("lit_single_rise0", r0, (k == 3 + D));
      check("lit_single_fall0", f0, (k == 6 + D));
      check("lit_single_rise1", r1, (k == 3 + D));
      check("lit_single_fall1", f1, (k == 1 + D) || (k == 6 + D));
    end

    // Toggle every cycle.
    for (int k = 1; k <= 4 + D; k++) begin
      cycle((k <= 4) ? seq_toggle[k-1] : 1'b0);
      check("lit_toggle_rise0", r0, (k == 1 + D) || (k == 3 + D));
      check("lit_toggle_fall0", f0, (k == 2 + D) || (k == 4 + D));
    end

    // Random stress: pulse count must equal transition count.
    trans    = 0;
    prev_v   = 1'b0;
    count_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v != prev_v) trans++;
      prev_v = v;
      cycle(v);
    end
    repeat (D) cycle(prev_v);
    count_en = 1'b0;
    checks++;
    if (pulses != trans) begin
      errors++;
      $display("FAIL pulse_count: got %0d expected %0d", pulses, trans);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
